// File: rtl/led_counter_ctrl.sv
// Push-button mode controller for a free-running 32-bit LED counter.
// Debounced short presses cycle SLOW/FAST/PAUSE; a long press clears the counter.
module led_counter_ctrl #(
  parameter int unsigned DEB_CNT  = 120000,
  parameter int unsigned LONG_CNT = 24000000,
  parameter int unsigned DIV_SLOW = 4
) (
  input  logic       clk_12,
  input  logic       rst_n,
  input  logic       SW2,
  input  logic       run,
  output logic       clk_en,
  output logic       aclr,
  output logic [1:0] mode
);

  localparam int unsigned DebW  = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int unsigned HoldW = $clog2(LONG_CNT + 1);

  localparam logic [DebW-1:0]  DebLast   = DebW'(DEB_CNT - 1);
  localparam logic [HoldW-1:0] HoldMax   = HoldW'(LONG_CNT);
  localparam logic [HoldW-1:0] HoldLast  = HoldW'(LONG_CNT - 1);
  localparam logic [15:0]      PrescLast = 16'(DIV_SLOW - 1);

  typedef enum logic [1:0] {
    ModeSlow  = 2'b00,
    ModeFast  = 2'b01,
    ModePause = 2'b10
  } mode_e;

  logic             sw2_s1_q, sw2_s2_q;
  logic             run_s1_q, run_s2_q;
  logic             db_q, db_d;
  logic [DebW-1:0]  deb_q, deb_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [15:0]      presc_q, presc_d;
  mode_e            mode_q, mode_d;
  logic             clk_en_q, clk_en_d;
  logic             aclr_q, aclr_d;

  logic pressed_sync, long_hit, short_rel, wrap;

  always_comb begin
    pressed_sync = ~sw2_s2_q;

    // Stability counter only runs while the synced level disagrees with db_q.
    db_d  = db_q;
    deb_d = '0;
    if (pressed_sync != db_q) begin
      if (deb_q == DebLast) begin
        db_d = pressed_sync;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end

    hold_d   = '0;
    long_hit = 1'b0;
    if (db_q) begin
      if (hold_q == HoldMax) begin
        hold_d = hold_q;
      end else begin
        hold_d   = hold_q + 1'b1;
        long_hit = (hold_q == HoldLast);
      end
    end

    // A saturated hold counter means the press already cleared; its release is ignored.
    short_rel = db_q & ~db_d & (hold_q != HoldMax);

    mode_d = mode_q;
    if (long_hit) begin
      mode_d = ModeSlow;
    end else if (short_rel) begin
      case (mode_q)
        ModeSlow: mode_d = ModeFast;
        ModeFast: mode_d = ModePause;
        default:  mode_d = ModeSlow;
      endcase
    end

    presc_d = presc_q;
    wrap    = 1'b0;
    if (long_hit || (mode_d != mode_q)) begin
      presc_d = '0;
    end else if ((mode_q == ModeSlow) && run_s2_q) begin
      if (presc_q == PrescLast) begin
        presc_d = '0;
        wrap    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    clk_en_d = 1'b0;
    if (run_s2_q && !long_hit) begin
      case (mode_d)
        ModeFast: clk_en_d = 1'b1;
        ModeSlow: clk_en_d = wrap;
        default:  clk_en_d = 1'b0;
      endcase
    end

    aclr_d = long_hit;
  end

  always_ff @(posedge clk_12 or negedge rst_n) begin
    if (!rst_n) begin
      sw2_s1_q <= 1'b1;
      sw2_s2_q <= 1'b1;
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      db_q     <= 1'b0;
      deb_q    <= '0;
      hold_q   <= '0;
      presc_q  <= '0;
      mode_q   <= ModeSlow;
      clk_en_q <= 1'b0;
      aclr_q   <= 1'b0;
    end else begin
      sw2_s1_q <= SW2;
      sw2_s2_q <= sw2_s1_q;
      run_s1_q <= run;
      run_s2_q <= run_s1_q;
      db_q     <= db_d;
      deb_q    <= deb_d;
      hold_q   <= hold_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      clk_en_q <= clk_en_d;
      aclr_q   <= aclr_d;
    end
  end

  assign clk_en = clk_en_q;
  assign aclr   = aclr_q;
  assign mode   = mode_q;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Bench for led_counter_ctrl: directed scenarios plus random button/run traffic,
// all outputs compared every cycle against a cycle-level behavioural model.
module tb_led_counter_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam int unsigned DIV  = 3;

  logic       clk_12 = 1'b0;
  logic       rst_n  = 1'b0;
  logic       SW2    = 1'b1;
  logic       run    = 1'b0;
  logic       clk_en, aclr;
  logic [1:0] mode;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_12 = ~clk_12;

  led_counter_ctrl #(
    .DEB_CNT (DEB),
    .LONG_CNT(LONG),
    .DIV_SLOW(DIV)
  ) dut (
    .clk_12(clk_12),
    .rst_n (rst_n),
    .SW2   (SW2),
    .run   (run),
    .clk_en(clk_en),
    .aclr  (aclr),
    .mode  (mode)
  );

  // Reference model state: mode as 0=SLOW 1=FAST 2=PAUSE, phase counts slow ticks.
  bit m_sw1, m_sw2, m_run1, m_run2, m_db, m_en, m_clr;
  int m_stab, m_hold, m_mode, m_phase;

  task automatic model_reset();
    m_sw1 = 1; m_sw2 = 1; m_run1 = 0; m_run2 = 0; m_db = 0;
    m_stab = 0; m_hold = 0; m_mode = 0; m_phase = 0; m_en = 0; m_clr = 0;
  endtask

  task automatic model_step(input bit sw, input bit rn);
    bit pressed, ndb, long_hit, fall, wrap;
    int nstab, nhold, nmode, nphase;
    pressed = !m_sw2;
    ndb     = m_db;
    nstab   = 0;
    if (pressed != m_db) begin
      nstab = m_stab + 1;
      if (nstab == DEB) begin
        ndb   = pressed;
        nstab = 0;
      end
    end
    nhold    = m_db ? ((m_hold + 1 > LONG) ? LONG : m_hold + 1) : 0;
    long_hit = (nhold == LONG) && (m_hold != LONG);
    fall     = m_db && !ndb;
    if (long_hit)                    nmode = 0;
    else if (fall && m_hold < LONG)  nmode = (m_mode + 1) % 3;
    else                             nmode = m_mode;
    wrap   = 0;
    nphase = m_phase;
    if (long_hit || nmode != m_mode) nphase = 0;
    else if (m_mode == 0 && m_run2) begin
      nphase = (m_phase + 1) % DIV;
      wrap   = (nphase == 0);
    end
    m_en    = m_run2 && !long_hit && (nmode == 1 || (nmode == 0 && wrap));
    m_clr   = long_hit;
    m_db    = ndb;
    m_stab  = nstab;
    m_hold  = nhold;
    m_mode  = nmode;
    m_phase = nphase;
    m_sw2   = m_sw1;
    m_sw1   = sw;
    m_run2  = m_run1;
    m_run1  = rn;
  endtask

  // Advance one clock; returns 1 ns after the edge so outputs are settled.
  task automatic step();
    @(posedge clk_12);
    if (rst_n) model_step(SW2, run);
    #1;
  endtask

  task automatic press(input int len);
    SW2 = 1'b0;
    repeat (len) step();
    SW2 = 1'b1;
    repeat (DEB + 6) step();
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    run   = 1'b1;
    SW2   = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode got=%b exp=00", mode); end
    n_cmp++;
    if (clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en got=%b exp=0", clk_en); end
    n_cmp++;
    if (aclr !== 1'b0) begin n_fail++; $display("FAIL reset_aclr got=%b exp=0", aclr); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_slow();
    int last, first;
    last = -1; first = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      n_cmp++;
      if ({clk_en, aclr, mode} !== {m_en, m_clr, 2'(m_mode)}) begin
        n_fail++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", i, {clk_en, aclr, mode},
                 {m_en, m_clr, 2'(m_mode)});
      end
      if (clk_en === 1'b1) begin
        if (first < 0) first = i;
        if (last >= 0) begin
          n_cmp++;
          if (i - last != DIV) begin
            n_fail++; $display("FAIL idle_period got=%0d exp=%0d", i - last, DIV);
          end
        end
        last = i;
      end
    end
    n_cmp++;
    if (first < 0) begin n_fail++; $display("FAIL idle_no_pulse got=none exp=pulse"); end
  endtask

  task automatic test_short_press();
    SW2 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) SW2 = 1'b1;
      step();
      n_cmp++;
      if ({clk_en, aclr, mode} !== {m_en, m_clr, 2'(m_mode)}) begin
        n_fail++;
        $display("FAIL short1 cyc=%0d got=%b exp=%b", i, {clk_en, aclr, mode},
                 {m_en, m_clr, 2'(m_mode)});
      end
    end
    n_cmp++;
    if ({mode, clk_en} !== 3'b01_1) begin
      n_fail++; $display("FAIL short1_fast got=%b exp=011", {mode, clk_en});
    end
    SW2 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) SW2 = 1'b1;
      step();
      n_cmp++;
      if ({clk_en, aclr, mode} !== {m_en, m_clr, 2'(m_mode)}) begin
        n_fail++;
        $display("FAIL short2 cyc=%0d got=%b exp=%b", i, {clk_en, aclr, mode},
                 {m_en, m_clr, 2'(m_mode)});
      end
    end
    n_cmp++;
    if ({mode, clk_en} !== 3'b10_0) begin
      n_fail++; $display("FAIL short2_pause got=%b exp=100", {mode, clk_en});
    end
  endtask

  task automatic test_glitch();
    logic [1:0] start_mode;
    int cyc, saw_clr, len;
    start_mode = mode;
    cyc = 0; saw_clr = 0;
    while (cyc < 50) begin
      SW2 = ~SW2;
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) begin
        step();
        cyc++;
        if (aclr === 1'b1) saw_clr++;
        n_cmp++;
        if ({clk_en, aclr, mode} !== {m_en, m_clr, 2'(m_mode)}) begin
          n_fail++;
          $display("FAIL glitch cyc=%0d got=%b exp=%b", cyc, {clk_en, aclr, mode},
                   {m_en, m_clr, 2'(m_mode)});
        end
      end
    end
    SW2 = 1'b1;
    repeat (DEB + 4) step();
    n_cmp++;
    if (mode !== start_mode) begin
      n_fail++; $display("FAIL glitch_mode got=%b exp=%b", mode, start_mode);
    end
    n_cmp++;
    if (saw_clr != 0) begin n_fail++; $display("FAIL glitch_aclr got=%0d exp=0", saw_clr); end
  endtask

  task automatic test_long_press();
    int clr_cnt, clr_cyc;
    press(5);
    press(5);
    n_cmp++;
    if (mode !== 2'b01) begin n_fail++; $display("FAIL long_pre got=%b exp=01", mode); end
    clr_cnt = 0; clr_cyc = -1;
    SW2 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 41) SW2 = 1'b1;
      step();
      n_cmp++;
      if ({clk_en, aclr, mode} !== {m_en, m_clr, 2'(m_mode)}) begin
        n_fail++;
        $display("FAIL long cyc=%0d got=%b exp=%b", i, {clk_en, aclr, mode},
                 {m_en, m_clr, 2'(m_mode)});
      end
      if (aclr === 1'b1) begin
        clr_cnt++;
        clr_cyc = i;
        n_cmp++;
        if ({clk_en, mode} !== 3'b0_00) begin
          n_fail++; $display("FAIL long_clr_cycle got=%b exp=000", {clk_en, mode});
        end
      end
    end
    n_cmp++;
    if (clr_cnt != 1) begin n_fail++; $display("FAIL long_pulses got=%0d exp=1", clr_cnt); end
    // Two synchronizer flops plus the debounce window before db_pressed rises.
    n_cmp++;
    if (clr_cyc != 2 + DEB + LONG) begin
      n_fail++; $display("FAIL long_timing got=%0d exp=%0d", clr_cyc, 2 + DEB + LONG);
    end
    n_cmp++;
    if (mode !== 2'b00) begin n_fail++; $display("FAIL long_release got=%b exp=00", mode); end
  endtask

  task automatic test_run_freeze();
    int seen;
    seen = 0;
    run = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (i == 11) run = 1'b1;
      step();
      if (i >= 3 && i <= 12 && clk_en === 1'b1) seen++;
      n_cmp++;
      if ({clk_en, aclr, mode} !== {m_en, m_clr, 2'(m_mode)}) begin
        n_fail++;
        $display("FAIL freeze cyc=%0d got=%b exp=%b", i, {clk_en, aclr, mode},
                 {m_en, m_clr, 2'(m_mode)});
      end
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL freeze_en got=%0d exp=0", seen); end
  endtask

  task automatic test_reset_mid_press();
    int k, guard, clr;
    guard = 0; clr = 0;
    SW2 = 1'b0;
    while (m_hold != 15 && guard < 80) begin
      step();
      guard++;
    end
    n_cmp++;
    if (m_hold != 15) begin n_fail++; $display("FAIL rmid_reach got=%0d exp=15", m_hold); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({clk_en, aclr, mode} !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_async got=%b exp=0000", {clk_en, aclr, mode});
    end
    repeat (2) step();
    rst_n = 1'b1;
    k = $urandom_range(1, 9);
    for (int i = 1; i <= k + 15; i++) begin
      if (i == k + 1) SW2 = 1'b1;
      step();
      if (aclr === 1'b1) clr++;
      n_cmp++;
      if ({clk_en, aclr, mode} !== {m_en, m_clr, 2'(m_mode)}) begin
        n_fail++;
        $display("FAIL rmid cyc=%0d k=%0d got=%b exp=%b", i, k, {clk_en, aclr, mode},
                 {m_en, m_clr, 2'(m_mode)});
      end
    end
    n_cmp++;
    if (clr != 0) begin n_fail++; $display("FAIL rmid_aclr got=%0d exp=0", clr); end
    n_cmp++;
    if (mode !== ((k >= DEB) ? 2'b01 : 2'b00)) begin
      n_fail++; $display("FAIL rmid_mode k=%0d got=%b", k, mode);
    end
  endtask

  task automatic test_random();
    int sw_left, run_left;
    sw_left = 0; run_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (sw_left == 0) begin
        SW2 = ~SW2;
        sw_left = $urandom_range(1, 32);
      end
      if (run_left == 0) begin
        run = ($urandom_range(0, 3) != 0);
        run_left = $urandom_range(1, 40);
      end
      sw_left--;
      run_left--;
      step();
      n_cmp++;
      if ({clk_en, aclr, mode} !== {m_en, m_clr, 2'(m_mode)}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, {clk_en, aclr, mode},
                 {m_en, m_clr, 2'(m_mode)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_slow();
    test_short_press();
    test_glitch();
    test_long_press();
    test_run_freeze();
    test_reset_mid_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
